// File: rtl/uart_cmd_seq.sv
// UART command sequencer: parses COM/ADR_H/ADR_L/LEN packets from a byte
// stream, issues write strobes for write packets and streams read-back data
// to the UART transmitter for read packets. An inter-byte timeout aborts
// stalled packets with a one-cycle err pulse.
module uart_cmd_seq #(
    parameter int TO_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_rx,
    input  logic [7:0]  rx_dat,
    input  logic [7:0]  my_dat,
    input  logic        tx_busy,
    output logic [7:0]  com,
    output logic [15:0] wr_adr,
    output logic [15:0] rd_adr,
    output logic [7:0]  wr_dat,
    output logic        ce_wr_dat,
    output logic [7:0]  tx_dat,
    output logic        st_tx,
    output logic        busy,
    output logic        err
);

    localparam int TW = $clog2(TO_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_AH,
        GET_AL,
        GET_LEN,
        WDAT,
        RWAIT,
        TXST,
        TXW
    } state_t;

    state_t        state, nxt;

    // Registered datapath and its next-state values
    logic [15:0]   adr, adr_n;
    logic [7:0]    com_n, wr_dat_n, tx_dat_n;
    logic [15:0]   wr_adr_n, rd_adr_n;
    logic          ce_wr_n, st_tx_n, err_n;
    logic [8:0]    cnt, cnt_n;          // bytes remaining; 256 needs the 9th bit
    logic [TW-1:0] to_cnt, to_n;        // cycles since the last received byte
    logic          rw_sec, rw_sec_n;    // second cycle of RWAIT
    logic          txw_first, txw_first_n;

    logic          timed;
    logic          to_exp;

    assign busy = (state != IDLE);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Datapath and strobe registers, all cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com       <= '0;
            adr       <= '0;
            wr_adr    <= '0;
            rd_adr    <= '0;
            wr_dat    <= '0;
            ce_wr_dat <= 1'b0;
            tx_dat    <= '0;
            st_tx     <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            to_cnt    <= '0;
            rw_sec    <= 1'b0;
            txw_first <= 1'b0;
        end else begin
            com       <= com_n;
            adr       <= adr_n;
            wr_adr    <= wr_adr_n;
            rd_adr    <= rd_adr_n;
            wr_dat    <= wr_dat_n;
            ce_wr_dat <= ce_wr_n;
            tx_dat    <= tx_dat_n;
            st_tx     <= st_tx_n;
            err       <= err_n;
            cnt       <= cnt_n;
            to_cnt    <= to_n;
            rw_sec    <= rw_sec_n;
            txw_first <= txw_first_n;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        nxt         = state;
        com_n       = com;
        adr_n       = adr;
        wr_adr_n    = wr_adr;
        rd_adr_n    = rd_adr;
        wr_dat_n    = wr_dat;
        ce_wr_n     = 1'b0;
        tx_dat_n    = tx_dat;
        st_tx_n     = 1'b0;
        err_n       = 1'b0;
        cnt_n       = cnt;
        rw_sec_n    = 1'b0;
        txw_first_n = 1'b0;

        // Timeout only runs while a packet is being received; a byte that
        // arrives in the expiry cycle restarts the count and wins.
        timed  = (state == GET_AH) || (state == GET_AL) ||
                 (state == GET_LEN) || (state == WDAT);
        to_exp = timed && !ce_rx && (to_cnt == TW'(TO_CYC - 1));
        to_n   = (ce_rx || !timed) ? '0 : to_cnt + TW'(1);

        // The address advances in the cycle after each write strobe
        if (ce_wr_dat) wr_adr_n = wr_adr + 16'd1;

        case (state)
            IDLE: begin
                if (ce_rx) begin
                    com_n = rx_dat;
                    nxt   = GET_AH;
                end
            end
            GET_AH: begin
                if (ce_rx) begin
                    adr_n[15:8] = rx_dat;
                    nxt         = GET_AL;
                end else if (to_exp) begin
                    err_n = 1'b1;
                    nxt   = IDLE;
                end
            end
            GET_AL: begin
                if (ce_rx) begin
                    adr_n[7:0] = rx_dat;
                    nxt        = GET_LEN;
                end else if (to_exp) begin
                    err_n = 1'b1;
                    nxt   = IDLE;
                end
            end
            GET_LEN: begin
                if (ce_rx) begin
                    cnt_n = {(rx_dat == 8'h00), rx_dat};
                    if (com[7]) begin
                        rd_adr_n = adr;
                        nxt      = RWAIT;
                    end else begin
                        wr_adr_n = adr;
                        nxt      = WDAT;
                    end
                end else if (to_exp) begin
                    err_n = 1'b1;
                    nxt   = IDLE;
                end
            end
            WDAT: begin
                // cnt reaches zero in the cycle the last strobe is out
                if (cnt == 9'd0) begin
                    nxt = IDLE;
                end else if (ce_rx) begin
                    ce_wr_n  = 1'b1;
                    wr_dat_n = rx_dat;
                    cnt_n    = cnt - 9'd1;
                end else if (to_exp) begin
                    err_n = 1'b1;
                    nxt   = IDLE;
                end
            end
            RWAIT: begin
                // Two cycles of stable rd_adr before sampling read-back data
                if (rw_sec) begin
                    tx_dat_n = my_dat;
                    nxt      = TXST;
                end else begin
                    rw_sec_n = 1'b1;
                end
            end
            TXST: begin
                if (!tx_busy) begin
                    st_tx_n     = 1'b1;
                    txw_first_n = 1'b1;
                    nxt         = TXW;
                end
            end
            TXW: begin
                // tx_busy may not have risen yet in the first cycle after st_tx
                if (!txw_first && !tx_busy) begin
                    cnt_n = cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        nxt = IDLE;
                    end else begin
                        rd_adr_n = rd_adr + 16'd1;
                        nxt      = RWAIT;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Testbench for uart_cmd_seq: directed packets with a queue-based scoreboard
// for write strobes, transmit starts and timeout errors.
module tb_uart_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_rx = 1'b0;
    logic [7:0]  rx_dat = 8'h00;
    logic [7:0]  my_dat;
    logic        tx_busy = 1'b0;
    logic [7:0]  com;
    logic [15:0] wr_adr;
    logic [15:0] rd_adr;
    logic [7:0]  wr_dat;
    logic        ce_wr_dat;
    logic [7:0]  tx_dat;
    logic        st_tx;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    logic slow_tx = 1'b0;
    int busy_left = 0;

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  dat;
    } xact_t;

    xact_t wq[$];
    xact_t tq[$];
    int    eq[$];
    xact_t mon_x;
    int    mon_c;

    uart_cmd_seq #(.TO_CYC(20)) dut (
        .clk(clk), .rst(rst), .ce_rx(ce_rx), .rx_dat(rx_dat),
        .my_dat(my_dat), .tx_busy(tx_busy), .com(com),
        .wr_adr(wr_adr), .rd_adr(rd_adr), .wr_dat(wr_dat),
        .ce_wr_dat(ce_wr_dat), .tx_dat(tx_dat), .st_tx(st_tx),
        .busy(busy), .err(err)
    );

    // Memory model: read-back data is the low byte of the read address
    assign my_dat = rd_adr[7:0];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slow transmitter: busy for 10 cycles after each start
    always @(negedge clk) begin
        if (st_tx && slow_tx) begin
            busy_left <= 10;
            tx_busy   <= 1'b1;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
            tx_busy   <= 1'b1;
        end else begin
            busy_left <= 0;
            tx_busy   <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents an output event
    always @(negedge clk) begin
        if (ce_wr_dat) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected actual adr=%h dat=%h expected none", wr_adr, wr_dat);
            end else begin
                mon_x = wq.pop_front();
                chk("wr_adr", {16'h0, wr_adr}, {16'h0, mon_x.adr});
                chk("wr_dat", {24'h0, wr_dat}, {24'h0, mon_x.dat});
            end
        end
        if (st_tx) begin
            if (tq.size() == 0) begin
                checks++; errors++;
                $display("FAIL st_tx_unexpected actual rd_adr=%h tx_dat=%h expected none", rd_adr, tx_dat);
            end else begin
                mon_x = tq.pop_front();
                chk("rd_adr", {16'h0, rd_adr}, {16'h0, mon_x.adr});
                chk("tx_dat", {24'h0, tx_dat}, {24'h0, mon_x.dat});
            end
        end
        if (err) begin
            if (eq.size() == 0) begin
                checks++; errors++;
                $display("FAIL err_unexpected actual cycle=%0d expected none", cyc);
            end else begin
                mon_c = eq.pop_front();
                chk("err_cycle", cyc, mon_c);
                chk("err_busy", {31'h0, busy}, 32'h0);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ce_rx  = 1'b1;
        rx_dat = b;
        @(negedge clk);
        ce_rx  = 1'b0;
        last_rx_cyc = cyc;
    endtask

    task automatic push_w(input logic [15:0] a, input logic [7:0] d);
        xact_t x;
        x.adr = a;
        x.dat = d;
        wq.push_back(x);
    endtask

    task automatic push_t(input logic [15:0] a, input logic [7:0] d);
        xact_t x;
        x.adr = a;
        x.dat = d;
        tq.push_back(x);
    endtask

    task automatic wait_idle(input int lim, input string name);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_com"},    {24'h0, com},       32'h0);
        chk({tag, "_wr_adr"}, {16'h0, wr_adr},    32'h0);
        chk({tag, "_rd_adr"}, {16'h0, rd_adr},    32'h0);
        chk({tag, "_wr_dat"}, {24'h0, wr_dat},    32'h0);
        chk({tag, "_tx_dat"}, {24'h0, tx_dat},    32'h0);
        chk({tag, "_ce_wr"},  {31'h0, ce_wr_dat}, 32'h0);
        chk({tag, "_st_tx"},  {31'h0, st_tx},     32'h0);
        chk({tag, "_busy"},   {31'h0, busy},      32'h0);
        chk({tag, "_err"},    {31'h0, err},       32'h0);
    endtask

    initial begin
        int nst;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain write of three bytes
        push_w(16'h1234, 8'hAA);
        push_w(16'h1235, 8'hBB);
        push_w(16'h1236, 8'hCC);
        send(8'h00); send(8'h12); send(8'h34); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
        wait_idle(50, "write");
        chk("write_left", wq.size(), 0);
        chk("write_com", {24'h0, com}, 32'h00);

        // Read of two bytes with a slow transmitter
        slow_tx = 1'b1;
        push_t(16'h0001, 8'h01);
        push_t(16'h0002, 8'h02);
        send(8'h80); send(8'h00); send(8'h01); send(8'h02);
        wait_idle(400, "read");
        chk("read_left", tq.size(), 0);
        chk("read_rd_adr_hold", {16'h0, rd_adr}, 32'h0002);
        chk("read_com", {24'h0, com}, 32'h80);
        slow_tx = 1'b0;
        repeat (12) @(negedge clk);

        // Address wrap
        push_w(16'hFFFF, 8'h11);
        push_w(16'h0000, 8'h22);
        send(8'h01); send(8'hFF); send(8'hFF); send(8'h02);
        send(8'h11); send(8'h22);
        wait_idle(50, "wrap");
        chk("wrap_left", wq.size(), 0);

        // Byte arriving in the expiry cycle wins over the timeout
        push_w(16'h0010, 8'h5E);
        send(8'h00); send(8'h00); send(8'h10);
        repeat (18) @(negedge clk);
        send(8'h01);
        send(8'h5E);
        wait_idle(50, "to_edge");
        chk("to_edge_left", wq.size(), 0);

        // Timeout in GET_LEN, then a new COM byte, then a timeout in GET_AH
        send(8'h00); send(8'h00); send(8'h10);
        eq.push_back(last_rx_cyc + 20);
        repeat (25) @(negedge clk);
        chk("to_err_left", eq.size(), 0);
        chk("to_busy", {31'h0, busy}, 32'h0);
        send(8'h81);
        chk("to_new_com", {24'h0, com}, 32'h81);
        eq.push_back(last_rx_cyc + 20);
        wait_idle(60, "to_second");
        chk("to_err2_left", eq.size(), 0);

        // Reset during TXW of a 256-byte read burst
        push_t(16'h0000, 8'h00);
        push_t(16'h0001, 8'h01);
        push_t(16'h0002, 8'h02);
        send(8'h81); send(8'h00); send(8'h00); send(8'h00);
        nst = 0;
        for (int i = 0; i < 100 && nst < 3; i++) begin
            @(negedge clk);
            if (st_tx) nst++;
        end
        chk("rst_reach_txw", nst, 3);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (600) @(negedge clk);
        chk("rst_tx_left", tq.size(), 0);
        push_w(16'h4000, 8'h77);
        send(8'h00); send(8'h40); send(8'h00); send(8'h01); send(8'h77);
        wait_idle(50, "post_rst");
        chk("post_rst_left", wq.size(), 0);

        // LEN=0 write of 256 bytes
        for (int i = 0; i < 256; i++) push_w(16'(i), 8'(i) ^ 8'h5A);
        send(8'h00); send(8'h00); send(8'h00); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i) ^ 8'h5A);
        wait_idle(50, "len0");
        chk("len0_left", wq.size(), 0);
        chk("len0_wr_adr", {16'h0, wr_adr}, 32'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_cmd_seq.md
UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

Interface
REQ-001 The block SHALL have parameter TO_CYC, default 50000, giving the inter-byte timeout in clk cycles.
REQ-002 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port ce_rx  input  1  one-cycle strobe: rx_dat holds a newly received UART byte.
REQ-005 Port rx_dat  input  8  received byte, valid while ce_rx=1.
REQ-006 Port my_dat  input  8  read-back data from register/memory blocks.
REQ-007 Port tx_busy  input  1  UART transmitter busy.
REQ-008 Port com  output  8  latched command byte of the current packet.
REQ-009 Port wr_adr  output  16  write address.
REQ-010 Port rd_adr  output  16  read address.
REQ-011 Port wr_dat  output  8  write data, valid while ce_wr_dat=1.
REQ-012 Port ce_wr_dat  output  1  one-cycle write strobe.
REQ-013 Port tx_dat  output  8  byte to transmit, valid while st_tx=1.
REQ-014 Port st_tx  output  1  one-cycle transmit start strobe.
REQ-015 Port busy  output  1  high whenever the FSM is not IDLE.
REQ-016 Port err  output  1  one-cycle timeout error pulse.

Function
REQ-017 Packet format SHALL be: COM, ADR_H, ADR_L, LEN, then LEN data bytes if COM[7]=0 (write) or none if COM[7]=1 (read).
REQ-018 LEN=0 SHALL mean 256 bytes; the internal byte counter SHALL be 9 bits.
REQ-019 FSM states SHALL be IDLE, GET_AH, GET_AL, GET_LEN, WDAT, RWAIT, TXST, TXW.
REQ-020 IDLE + ce_rx: latch com<=rx_dat, go to GET_AH.
REQ-021 GET_AH + ce_rx: latch address high byte, go to GET_AL.
REQ-022 GET_AL + ce_rx: latch address low byte, go to GET_LEN.
REQ-023 GET_LEN + ce_rx: load the counter; set wr_adr or rd_adr to the latched address; go to WDAT if com[7]=0, else RWAIT.
REQ-024 In WDAT, each ce_rx SHALL give, on the next cycle, ce_wr_dat=1 and wr_dat=rx_dat at the current wr_adr.
REQ-025 In WDAT, wr_adr SHALL increment in the cycle after the strobe, and the counter SHALL decrement.
REQ-026 After the last write strobe the FSM SHALL return to IDLE.
REQ-027 RWAIT SHALL hold exactly 2 cycles with rd_adr stable, then sample tx_dat<=my_dat and go to TXST.
REQ-028 TXST: when tx_busy=0, assert st_tx for one cycle and go to TXW; otherwise hold.
REQ-029 TXW SHALL ignore tx_busy in its first cycle.
REQ-030 TXW, from its second cycle, on tx_busy=0: decrement the counter; if the counter is zero go to IDLE, else increment rd_adr and go to RWAIT.
REQ-031 Addresses SHALL wrap modulo 2^16 (FFFF+1 = 0000).
REQ-032 ce_rx SHALL be ignored in RWAIT, TXST and TXW.
REQ-033 A timeout counter SHALL reset on every ce_rx and on entry to GET_AH.
REQ-034 In GET_AH, GET_AL, GET_LEN and WDAT, reaching TO_CYC cycles without ce_rx SHALL pulse err for one cycle and return the FSM to IDLE.
REQ-035 On a timeout no further ce_wr_dat SHALL be issued.
REQ-036 If ce_rx and timeout expiry occur in the same cycle, the byte SHALL win and no err SHALL be raised.
REQ-037 com SHALL hold its value until the next packet's COM byte.
REQ-038 wr_adr and rd_adr SHALL hold their values while the FSM is in IDLE.

Reset
REQ-039 rst=1 SHALL immediately force the FSM to IDLE.
REQ-040 rst=1 SHALL immediately clear com, wr_adr, rd_adr, wr_dat, tx_dat and both counters to 0.
REQ-041 rst=1 SHALL immediately force ce_wr_dat, st_tx, busy and err to 0.
REQ-042 A reset in mid-packet SHALL discard the packet; the first byte after reset release SHALL be taken as COM.

Verification
REQ-043 Write: bytes 00,12,34,03,AA,BB,CC -> three ce_wr_dat pulses with (wr_adr,wr_dat) = (1234,AA), (1235,BB), (1236,CC); busy low afterwards.
REQ-044 Read with slow TX: bytes 80,00,01,02, my_dat=rd_adr[7:0], tx_busy held high 10 cycles after each st_tx -> tx_dat 01 then 02 on st_tx, rd_adr 0001 then 0002; exactly two st_tx pulses.
REQ-045 Wrap: bytes 01,FF,FF,02,11,22 -> writes (FFFF,11) and (0000,22).
REQ-046 Timeout with TO_CYC=20: bytes 00,00,10 then silence -> err pulse 20 cycles after the last ce_rx, busy=0; next byte 81 latched as com.
REQ-047 Reset mid-read: assert rst during TXW of an 81,00,00,00 (256-byte) burst -> all outputs 0 in the same cycle and no st_tx after release.
REQ-048 LEN=0 write: 00,00,00,00 plus 256 data bytes -> 256 strobes, last at wr_adr 00FF, then IDLE.
